// File: rtl/wb_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arb_pkg: state encoding and rotating-priority helper for          |
// | the Wishbone round-robin arbiter.                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY   = 2'd1,
    ARB_TMOERR = 2'd2
  } arb_state_e;

  // Index of the first set bit scanning upward from ptr, wrapping at n; -1 if none.
  function automatic int first_set_from_ptr(input logic [7:0] req,
                                            input logic [2:0] ptr,
                                            input int         n);
    int         sel;
    logic [2:0] idx;
    sel = -1;
    for (int k = 0; k < 8; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && sel < 0 && req[idx]) sel = int'(idx);
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_rr_prio: combinational one-hot pick of the first requester at or  |
// | after the priority pointer.                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_rr_prio #(
  parameter int NM = 4
) (
  input  logic [NM-1:0] req,
  input  logic [2:0]    ptr,
  output logic [NM-1:0] gnt
);
  import wb_arb_pkg::*;

  logic [7:0] w_req8;
  int         w_idx;

  always_comb begin
    w_req8         = '0;
    w_req8[NM-1:0] = req;
    w_idx          = first_set_from_ptr(w_req8, ptr, NM);
    gnt            = '0;
    for (int i = 0; i < NM; i++) gnt[i] = (w_idx == i);
  end

endmodule
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_rr_arbiter: NM-master to one-slave Wishbone round-robin arbiter   |
// | with grant hold over bursts and a stall watchdog.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_rr_arbiter #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int NM  = 4,
  parameter int TMO = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic [NM*AW-1:0]     wbm_adr_i,
  input  logic [NM*DW-1:0]     wbm_dat_i,
  input  logic [NM*DW/8-1:0]   wbm_sel_i,
  input  logic [NM-1:0]        wbm_we_i,
  input  logic [NM-1:0]        wbm_cyc_i,
  input  logic [NM-1:0]        wbm_stb_i,
  input  logic [NM*3-1:0]      wbm_cti_i,
  input  logic [NM*2-1:0]      wbm_bte_i,
  output logic [DW-1:0]        wbm_dat_o,
  output logic [NM-1:0]        wbm_ack_o,
  output logic [NM-1:0]        wbm_err_o,
  output logic [NM-1:0]        wbm_rty_o,
  output logic [AW-1:0]        wbs_adr_o,
  output logic [DW-1:0]        wbs_dat_o,
  output logic [DW/8-1:0]      wbs_sel_o,
  output logic                 wbs_we_o,
  output logic                 wbs_cyc_o,
  output logic                 wbs_stb_o,
  output logic [2:0]           wbs_cti_o,
  output logic [1:0]           wbs_bte_o,
  input  logic [DW-1:0]        wbs_dat_i,
  input  logic                 wbs_ack_i,
  input  logic                 wbs_err_i,
  input  logic                 wbs_rty_i,
  output logic [NM-1:0]        grant_o
);
  import wb_arb_pkg::*;

  localparam int              c_sw  = DW / 8;
  localparam int              c_cw  = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [c_cw-1:0] c_tmo = c_cw'(TMO);

  arb_state_e      r_state, w_state_nxt;
  logic [NM-1:0]   r_grant, w_grant_nxt, w_prio_gnt;
  logic [2:0]      r_ptr, w_ptr_nxt, w_ptr_adv;
  logic [c_cw-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

  logic [AW-1:0]   w_adr;
  logic [DW-1:0]   w_dat;
  logic [c_sw-1:0] w_sel;
  logic            w_we, w_cyc, w_stb, w_resp;
  logic [2:0]      w_cti;
  logic [1:0]      w_bte;

  wb_rr_prio #(.NM(NM)) u_prio (
    .req (wbm_cyc_i),
    .ptr (r_ptr),
    .gnt (w_prio_gnt)
  );

  // Granted master's slice, selected through the one-hot grant.
  always_comb begin
    w_adr     = '0;
    w_dat     = '0;
    w_sel     = '0;
    w_we      = 1'b0;
    w_cyc     = 1'b0;
    w_stb     = 1'b0;
    w_cti     = '0;
    w_bte     = '0;
    w_ptr_adv = r_ptr;
    for (int i = 0; i < NM; i++) begin
      if (r_grant[i]) begin
        w_adr     = wbm_adr_i[i*AW +: AW];
        w_dat     = wbm_dat_i[i*DW +: DW];
        w_sel     = wbm_sel_i[i*c_sw +: c_sw];
        w_we      = wbm_we_i[i];
        w_cyc     = wbm_cyc_i[i];
        w_stb     = wbm_stb_i[i];
        w_cti     = wbm_cti_i[i*3 +: 3];
        w_bte     = wbm_bte_i[i*2 +: 2];
        w_ptr_adv = 3'((i + 1) % NM);
      end
    end
  end

  assign w_resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign wbm_dat_o = wbs_dat_i;
  assign grant_o   = r_grant;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    wbs_adr_o   = '0;
    wbs_dat_o   = '0;
    wbs_sel_o   = '0;
    wbs_we_o    = 1'b0;
    wbs_cyc_o   = 1'b0;
    wbs_stb_o   = 1'b0;
    wbs_cti_o   = '0;
    wbs_bte_o   = '0;
    wbm_ack_o   = '0;
    wbm_err_o   = '0;
    wbm_rty_o   = '0;
    case (r_state)
      ARB_IDLE: begin
        w_cnt_nxt = '0;
        if (|wbm_cyc_i) begin
          w_grant_nxt = w_prio_gnt;
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        wbs_adr_o = w_adr;
        wbs_dat_o = w_dat;
        wbs_sel_o = w_sel;
        wbs_we_o  = w_we;
        wbs_cyc_o = w_cyc;
        wbs_stb_o = w_stb;
        wbs_cti_o = w_cti;
        wbs_bte_o = w_bte;
        wbm_ack_o = r_grant & {NM{wbs_ack_i}};
        wbm_err_o = r_grant & {NM{wbs_err_i}};
        wbm_rty_o = r_grant & {NM{wbs_rty_i}};
        if (!w_cyc) begin
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_adv;
          w_cnt_nxt   = '0;
          w_state_nxt = ARB_IDLE;
        end else if (w_resp) begin
          w_cnt_nxt = '0;
        end else if (w_stb && TMO != 0) begin
          // A response in the limit cycle is caught by the branch above.
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == c_tmo) w_state_nxt = ARB_TMOERR;
        end
      end
      ARB_TMOERR: begin
        wbs_adr_o = w_adr;
        wbs_dat_o = w_dat;
        wbs_sel_o = w_sel;
        wbs_we_o  = w_we;
        wbs_cti_o = w_cti;
        wbs_bte_o = w_bte;
        wbm_err_o = r_grant;
        w_cnt_nxt = '0;
        if (w_cyc) begin
          w_state_nxt = ARB_BUSY;
        end else begin
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_adv;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter AW, default 32, address width in bits.
REQ-003 SHALL have parameter NM, default 4, number of masters (2..8).
REQ-004 SHALL have parameter TMO, default 255, watchdog limit in cycles (1..65535); 0 disables the watchdog.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, as follows:
 - wb_clk_i  in  1  sole clock; all state changes on its rising edge.
 - wb_rst_ni  in  1  asynchronous, active-low reset.
REQ-006 SHALL have these master-side ports, packed per master with master i at slice i:
 - wbm_adr_i  in  NM*AW  addresses.
 - wbm_dat_i  in  NM*DW  write data.
 - wbm_sel_i  in  NM*DW/8  byte selects.
 - wbm_we_i  in  NM  write enables.
 - wbm_cyc_i  in  NM  cycle requests.
 - wbm_stb_i  in  NM  strobes.
 - wbm_cti_i  in  NM*3  cycle type identifiers.
 - wbm_bte_i  in  NM*2  burst type extensions.
 - wbm_dat_o  out  DW  read data, broadcast to all masters.
 - wbm_ack_o  out  NM  per-master acknowledge.
 - wbm_err_o  out  NM  per-master error.
 - wbm_rty_o  out  NM  per-master retry.
REQ-007 SHALL have these slave-side ports:
 - wbs_adr_o  out  AW  address.
 - wbs_dat_o  out  DW  write data.
 - wbs_sel_o  out  DW/8  byte selects.
 - wbs_we_o  out  1  write enable.
 - wbs_cyc_o  out  1  cycle.
 - wbs_stb_o  out  1  strobe.
 - wbs_cti_o  out  3  cycle type identifier.
 - wbs_bte_o  out  2  burst type extension.
 - wbs_dat_i  in  DW  read data.
 - wbs_ack_i  in  1  acknowledge.
 - wbs_err_i  in  1  error.
 - wbs_rty_i  in  1  retry.
REQ-008 SHALL expose grant_o  out  NM  registered one-hot grant vector, for debug.

Function
REQ-009 SHALL implement states IDLE, BUSY and TMOERR.
REQ-010 In IDLE with any wbm_cyc_i set, SHALL load grant with the first requester at or after priority pointer ptr (wrapping NM-1 to 0) and move to BUSY on the next edge; IDLE to first wbs_cyc_o is exactly one cycle.
REQ-011 In IDLE with no request, SHALL keep grant at 0 and all slave-side outputs at 0.
REQ-012 In BUSY, SHALL drive wbs_adr/dat/sel/we/stb/cti/bte_o from the granted master's slice, and wbs_cyc_o = wbm_cyc_i[granted].
REQ-013 In BUSY, SHALL route wbs_ack_i, wbs_err_i and wbs_rty_i only to the granted master; all other masters see 0 on all three.
REQ-014 SHALL hold the grant across bursts (cti 001/010) and across back-to-back single accesses while the granted master keeps cyc high; other requests SHALL NOT preempt it.
REQ-015 When the granted master's cyc falls in BUSY, SHALL clear grant, set ptr to (granted index + 1) mod NM, and return to IDLE; re-arbitration takes effect on the following cycle.
REQ-016 When several masters request in the same IDLE cycle, SHALL select by REQ-010 order only; lower index wins only when ptr equals 0.
REQ-017 SHALL run a watchdog counter (width clog2(TMO+1)) that increments each BUSY cycle with wbs_stb_o high and none of ack/err/rty, and clears on any response or in IDLE.
REQ-018 When the counter reaches TMO, SHALL enter TMOERR for exactly one cycle: wbs_cyc_o and wbs_stb_o = 0, and wbm_err_o[granted] = 1; the next state is BUSY with the counter cleared if cyc is still high, otherwise IDLE with ptr advanced.
REQ-019 A slave response arriving in the same cycle the counter hits TMO SHALL win: it is forwarded and TMOERR is not entered.
REQ-020 wbm_dat_o SHALL equal wbs_dat_i combinationally in all states.
REQ-021 A master that drops cyc without having been granted SHALL have no effect on state.

Reset
REQ-022 Asserting wb_rst_ni low SHALL immediately set the state to IDLE, grant and grant_o to 0, ptr to 0 and the counter to 0, forcing all wbs_* outputs and wbm_ack/err/rty_o to 0, including mid-burst; release is synchronised by the system, not by this block.

Structure
REQ-023 SHALL place the state encoding and a first-set-from-pointer function in package wb_arb_pkg.
REQ-024 SHALL implement priority selection in the sub-module wb_rr_prio (inputs req[NM] and ptr; output one-hot gnt), purely combinational.

Verification
REQ-025 Scenario: masters 0 and 2 raise cyc together after reset -> master 0 granted, wbs_cyc_o high 1 cycle later; after master 0 drops cyc, master 2 granted.
REQ-026 Scenario: master 1 runs a 4-beat incrementing burst (cti 010,010,010,111) while master 3 requests -> exactly 4 acks go to master 1, master 3 is granted only after master 1 drops cyc.
REQ-027 Scenario: TMO=8, slave never responds -> wbm_err_o[granted] pulses 1 cycle after 8 stalled cycles, and wbs_cyc_o is low during that cycle.
REQ-028 Scenario: TMO=8, wbs_ack_i arrives on the 8th stalled cycle -> ack is forwarded and no err pulse occurs.
REQ-029 Scenario: wb_rst_ni is pulsed low mid-burst -> all outputs go to 0 asynchronously, and after release master 0 has first priority.
REQ-030 Scenario: all 4 masters request continuously with single accesses -> grants rotate 0,1,2,3,0, with no master starved.
